// File: rtl/clk_strobe_gen_pkg.sv
// Shared types and helpers for the programmable clock/strobe generator.
//   DEF_CNT_W  : default counter/ratio width
//   cfg_t      : channel configuration {div, high, phase} at maximum width
//   cnt_op_e   : per-cycle counter operation of a channel
//   clamp_cfg  : legalises a raw configuration write and flags any correction
package clk_gen_pkg;

    localparam int unsigned DEF_CNT_W = 20;
    localparam int unsigned MAX_CNT_W = 32;

    typedef logic [MAX_CNT_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t div;
        cnt_t high;
        cnt_t phase;
    } cfg_t;

    typedef struct packed {
        cfg_t cfg;
        logic clamped;
    } clamp_res_t;

    typedef enum logic [1:0] {
        CNT_IDLE,   // channel disabled: counter parked at 0
        CNT_LOAD,   // enable edge or sync: counter loads the phase offset
        CNT_WRAP,   // last count of the period: start a new period
        CNT_STEP    // ordinary increment
    } cnt_op_e;

    // The high and phase checks are made against the already-corrected div,
    // so the result is always self-consistent: 2 <= div, 1 <= high < div,
    // phase < div.
    function automatic clamp_res_t clamp_cfg(input cfg_t raw);
        clamp_res_t r;
        r.cfg     = raw;
        r.clamped = 1'b0;
        if (raw.div < cnt_t'(2)) begin
            r.cfg.div = cnt_t'(2);
            r.clamped = 1'b1;
        end
        if (raw.high == '0) begin
            r.cfg.high = r.cfg.div >> 1;
            r.clamped  = 1'b1;
        end else if (raw.high >= r.cfg.div) begin
            r.cfg.high = r.cfg.div - cnt_t'(1);
            r.clamped  = 1'b1;
        end
        if (raw.phase >= r.cfg.div) begin
            r.cfg.phase = '0;
            r.clamped   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_strobe_gen_if.sv
// Configuration and output bundle of clk_strobe_gen.
//   cfg_we/cfg_ch/cfg_div/cfg_high/cfg_phase : single-cycle config write
//   ch_en                                    : per-channel run enable (level)
//   sync_req                                 : phase-align pulse
//   strobe_out/clk_out                       : per-channel strobe and level
//   pend                                     : shadow config awaiting boundary
//   cfg_err                                  : clamp or bad-channel pulse
// master: driven by the configuring agent; slave: the generator itself.
interface clk_strobe_gen_if
    import clk_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = DEF_CNT_W
) ();

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [CNT_W-1:0]  cfg_high;
    logic [CNT_W-1:0]  cfg_phase;
    logic [NUM_CH-1:0] ch_en;
    logic              sync_req;
    logic [NUM_CH-1:0] strobe_out;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] pend;
    logic              cfg_err;

    modport master (
        output cfg_we, cfg_ch, cfg_div, cfg_high, cfg_phase, ch_en, sync_req,
        input  strobe_out, clk_out, pend, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_div, cfg_high, cfg_phase, ch_en, sync_req,
        output strobe_out, clk_out, pend, cfg_err
    );

endinterface

// File: rtl/clk_strobe_gen_ch.sv
// One channel of the clock/strobe generator: shadow and active configuration,
// period counter and registered outputs.
//   clk_i, rst_i       : clock, async active-high reset
//   en_i               : channel run enable (level)
//   sync_i             : phase-align request
//   we_i               : write of an already-clamped config to this channel
//   div_i/high_i/phase_i : the clamped config being written
//   strobe_o           : 1 in cycles where the counter is 0
//   clk_o              : 1 while the counter is below the high count
//   pend_o             : shadow config waiting for the period boundary
module clk_strobe_ch
    import clk_gen_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             we_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic [CNT_W-1:0] high_i,
    input  logic [CNT_W-1:0] phase_i,
    output logic             strobe_o,
    output logic             clk_o,
    output logic             pend_o
);

    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] phase;
    } ch_cfg_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEF_DIV / 2);

    ch_cfg_t          act_q, act_d;
    ch_cfg_t          shd_q, shd_d;
    ch_cfg_t          wr_cfg;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             en_q;
    logic             strobe_q, strobe_d;
    logic             clk_q, clk_d;
    cnt_op_e          op;

    always_comb begin
        op = CNT_IDLE;
        if (!en_i) begin
            op = CNT_IDLE;
        end else if (!en_q || sync_i) begin
            op = CNT_LOAD;
        end else if (cnt_q == act_q.div - ONE) begin
            op = CNT_WRAP;
        end else begin
            op = CNT_STEP;
        end
    end

    // Every op except STEP is a point where the shadow may legally become
    // active. While no write is pending the shadow equals the active config,
    // so applying it unconditionally is harmless. A write in the same cycle
    // only lands in the shadow, so LOAD/WRAP always see pre-write values.
    always_comb begin
        wr_cfg = '{div: div_i, high: high_i, phase: phase_i};
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        unique case (op)
            CNT_IDLE: begin
                act_d  = shd_q;
                pend_d = 1'b0;
                cnt_d  = '0;
            end
            CNT_LOAD: begin
                act_d  = shd_q;
                pend_d = 1'b0;
                cnt_d  = shd_q.phase;
            end
            CNT_WRAP: begin
                act_d  = shd_q;
                pend_d = 1'b0;
                cnt_d  = '0;
            end
            CNT_STEP: begin
                cnt_d = cnt_q + ONE;
            end
            default: begin
                cnt_d = '0;
            end
        endcase

        if (we_i) begin
            shd_d = wr_cfg;
            if (en_i) begin
                pend_d = 1'b1;
            end else begin
                act_d = wr_cfg;
            end
        end

        // Outputs are decoded from the next counter value so the registered
        // outputs line up with the counter value of the same cycle.
        strobe_d = en_i && (cnt_d == '0);
        clk_d    = en_i && (cnt_d < act_d.high);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_q    <= '{div: RST_DIV, high: RST_HIGH, phase: '0};
            shd_q    <= '{div: RST_DIV, high: RST_HIGH, phase: '0};
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            en_q     <= 1'b0;
            strobe_q <= 1'b0;
            clk_q    <= 1'b0;
        end else begin
            act_q    <= act_d;
            shd_q    <= shd_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            en_q     <= en_i;
            strobe_q <= strobe_d;
            clk_q    <= clk_d;
        end
    end

    assign strobe_o = strobe_q;
    assign clk_o    = clk_q;
    assign pend_o   = pend_q;

endmodule

// File: rtl/clk_strobe_gen.sv
// Multi-channel programmable clock/strobe generator. Each channel divides
// clk_in by a runtime ratio and produces a one-cycle strobe per period and a
// duty-programmable level, with phase offset, enable and a global sync.
//   clk_in : system clock
//   rst    : async active-high reset
//   bus    : configuration inputs and channel outputs (clk_strobe_gen_if.slave)
module clk_strobe_gen
    import clk_gen_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic              clk_in,
    input  logic              rst,
    clk_strobe_gen_if.slave   bus
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    cfg_t              raw;
    clamp_res_t        res;
    logic              ch_ok;
    logic              err_d, err_q;
    logic [NUM_CH-1:0] ch_we;
    logic [NUM_CH-1:0] strobe_w;
    logic [NUM_CH-1:0] clk_w;
    logic [NUM_CH-1:0] pend_w;

    // A single clamp serves all channels since only one write occurs per cycle.
    always_comb begin
        raw.div   = cnt_t'(bus.cfg_div);
        raw.high  = cnt_t'(bus.cfg_high);
        raw.phase = cnt_t'(bus.cfg_phase);
        res       = clamp_cfg(raw);
        ch_ok     = (32'(bus.cfg_ch) < NUM_CH);
        err_d     = bus.cfg_we && (!ch_ok || res.clamped);
    end

    if (CNT_W < MAX_CNT_W) begin : g_hi_sink
        // Inputs are zero-extended, so clamped results never use these bits.
        logic unused_hi;
        assign unused_hi = ^{res.cfg.div[MAX_CNT_W-1:CNT_W],
                             res.cfg.high[MAX_CNT_W-1:CNT_W],
                             res.cfg.phase[MAX_CNT_W-1:CNT_W]};
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_we[i] = bus.cfg_we && ch_ok && (bus.cfg_ch == CH_W'(i));

        clk_strobe_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk_i    (clk_in),
            .rst_i    (rst),
            .en_i     (bus.ch_en[i]),
            .sync_i   (bus.sync_req),
            .we_i     (ch_we[i]),
            .div_i    (res.cfg.div[CNT_W-1:0]),
            .high_i   (res.cfg.high[CNT_W-1:0]),
            .phase_i  (res.cfg.phase[CNT_W-1:0]),
            .strobe_o (strobe_w[i]),
            .clk_o    (clk_w[i]),
            .pend_o   (pend_w[i])
        );
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.strobe_out = strobe_w;
    assign bus.clk_out    = clk_w;
    assign bus.pend       = pend_w;
    assign bus.cfg_err    = err_q;

endmodule
